// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the host-to-async-SRAM bridge.
//   - state_t       : bridge FSM states
//   - DEF_*         : default parameter values of sram_bridge
//   - TIMER_W       : width of the per-beat wait counter (WAIT_CYC range 0..7)
//   - beat_cycles() : number of access cycles one SRAM beat occupies
package sram_bridge_pkg;

    localparam int DEF_SRAM_AW  = 18;
    localparam int DEF_BEATS    = 2;
    localparam int DEF_WAIT_CYC = 1;
    localparam int DEF_BEAT_CYC = DEF_WAIT_CYC + 1;
    localparam int TIMER_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ACC  = 3'd1,
        ST_WR_HOLD = 3'd2,
        ST_RD_ACC  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Access cycles spent with strobes asserted for one beat.
    function automatic int beat_cycles(input int wait_cyc);
        return wait_cyc + 1;
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Per-beat access timer.
//   clk, rst_n : clock, async active-low reset
//   load       : (re)start a beat; counter takes load_val
//   load_val   : cycles-1 the beat must last
//   en         : a beat is in progress
//   done       : high in the last cycle of the beat (combinational pulse)
module sram_beat_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = en && (cnt == '0);

endmodule

// File: rtl/sram_bridge.sv
// Host word interface to a 16-bit asynchronous SRAM.
// Host side:
//   i_req/o_ready : a request is taken on a clock edge where i_req=1 and
//                   o_ready=1; o_ready is high only while idle, and the
//                   request fields are captured on that same edge.
//   i_we, i_addr, i_wdata, i_be : request fields (write, word address,
//                   data, per-byte enables; beat b = 16-bit slice b)
//   o_ack         : one-cycle completion pulse
//   o_rdata       : read data, updated only when a read completes
// SRAM side:
//   SRAM_ADDR, SRAM_DQ (bidirectional), SRAM_CE_N/WE_N/OE_N/LB_N/UB_N.
//   All SRAM outputs come straight from flops, computed from next state.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int SRAM_AW  = DEF_SRAM_AW,
    parameter int BEATS    = DEF_BEATS,
    parameter int WAIT_CYC = DEF_WAIT_CYC,
    localparam int HOST_W  = 16 * BEATS,
    localparam int BE_W    = 2 * BEATS,
    localparam int SEL_W   = $clog2(BEATS),
    localparam int HAW     = SRAM_AW - SEL_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [HAW-1:0]    i_addr,
    input  logic [HOST_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic              o_ready,
    output logic              o_ack,
    output logic [HOST_W-1:0] o_rdata,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    // Beat index keeps at least one bit so BEATS=1 still elaborates; it
    // simply stays 0 in that case.
    localparam int BIDX_W = (BEATS > 1) ? SEL_W : 1;
    localparam logic [BIDX_W-1:0]  LAST_BEAT = BIDX_W'(BEATS - 1);
    localparam logic [TIMER_W-1:0] LOAD_VAL  = TIMER_W'(beat_cycles(WAIT_CYC) - 1);

    state_t              state, state_nxt;
    logic [BIDX_W-1:0]   beat, beat_nxt;
    logic [HAW-1:0]      addr_q;
    logic [HOST_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                accept;
    logic [BIDX_W:0]     hit;
    logic                tmr_load, tmr_en, tmr_done;
    logic                cap, cap_last;
    logic [HOST_W-1:0]   rd_buf, rd_merge;

    // Request fields as they will be after this edge (lets the SRAM output
    // flops see the new request in the same cycle it is accepted).
    logic [HAW-1:0]      addr_e;
    logic [HOST_W-1:0]   wdata_e;
    logic [BE_W-1:0]     be_e;

    logic [SRAM_AW-1:0]  nx_addr;
    logic                nx_ce_n, nx_we_n, nx_oe_n, nx_lb_n, nx_ub_n;
    logic                nx_dq_oe;
    logic [15:0]         nx_dq_out;
    logic                dq_oe;
    logic [15:0]         dq_out;

    // Lowest beat >= start whose byte-enable pair is nonzero.
    // Returns {found, index}.
    function automatic logic [BIDX_W:0] find_beat(input logic [BE_W-1:0] be,
                                                  input int start);
        logic [BIDX_W:0] r;
        r = '0;
        for (int b = BEATS - 1; b >= 0; b--) begin
            if ((b >= start) && (be[2*b +: 2] != 2'b00)) begin
                r = {1'b1, BIDX_W'(b)};
            end
        end
        return r;
    endfunction

    function automatic logic [SRAM_AW-1:0] make_addr(input logic [HAW-1:0] a,
                                                     input logic [BIDX_W-1:0] b);
        return (SRAM_AW'(a) << SEL_W) | SRAM_AW'(b);
    endfunction

    assign o_ready = (state == ST_IDLE);
    assign o_ack   = (state == ST_DONE);

    sram_beat_timer #(.CNT_W(TIMER_W)) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        accept    = 1'b0;
        hit       = '0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        cap       = 1'b0;
        cap_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    accept = 1'b1;
                    if (i_we) begin
                        // Writes start at the first enabled beat; with no
                        // enabled bytes at all there is nothing to access.
                        hit = find_beat(i_be, 0);
                        if (hit[BIDX_W]) begin
                            state_nxt = ST_WR_ACC;
                            beat_nxt  = hit[BIDX_W-1:0];
                            tmr_load  = 1'b1;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        state_nxt = ST_RD_ACC;
                        beat_nxt  = '0;
                        tmr_load  = 1'b1;
                    end
                end
            end
            ST_WR_ACC: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_nxt = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                hit = find_beat(be_q, int'(beat) + 1);
                if (hit[BIDX_W]) begin
                    state_nxt = ST_WR_ACC;
                    beat_nxt  = hit[BIDX_W-1:0];
                    tmr_load  = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RD_ACC: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    cap = 1'b1;
                    if (beat == LAST_BEAT) begin
                        cap_last  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        beat_nxt = beat + 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- FSM and request registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            beat    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (accept) begin
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                be_q    <= i_be;
            end
        end
    end

    // ---------------- SRAM output values for the next cycle ----------------
    always_comb begin
        addr_e  = accept ? i_addr  : addr_q;
        wdata_e = accept ? i_wdata : wdata_q;
        be_e    = accept ? i_be    : be_q;
    end

    always_comb begin
        int bi;
        bi        = int'(beat_nxt);
        nx_addr   = SRAM_ADDR;
        nx_ce_n   = 1'b1;
        nx_we_n   = 1'b1;
        nx_oe_n   = 1'b1;
        nx_lb_n   = 1'b1;
        nx_ub_n   = 1'b1;
        nx_dq_oe  = 1'b0;
        nx_dq_out = dq_out;
        case (state_nxt)
            ST_WR_ACC: begin
                nx_addr   = make_addr(addr_e, beat_nxt);
                nx_ce_n   = 1'b0;
                nx_we_n   = 1'b0;
                nx_lb_n   = ~be_e[2*bi];
                nx_ub_n   = ~be_e[2*bi+1];
                nx_dq_oe  = 1'b1;
                nx_dq_out = wdata_e[16*bi +: 16];
            end
            ST_WR_HOLD: begin
                // WE_N rises while address, lanes and data stay put.
                nx_addr   = make_addr(addr_e, beat_nxt);
                nx_ce_n   = 1'b0;
                nx_lb_n   = ~be_e[2*bi];
                nx_ub_n   = ~be_e[2*bi+1];
                nx_dq_oe  = 1'b1;
                nx_dq_out = wdata_e[16*bi +: 16];
            end
            ST_RD_ACC: begin
                nx_addr = make_addr(addr_e, beat_nxt);
                nx_ce_n = 1'b0;
                nx_oe_n = 1'b0;
                nx_lb_n = 1'b0;
                nx_ub_n = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            SRAM_ADDR <= nx_addr;
            SRAM_CE_N <= nx_ce_n;
            SRAM_WE_N <= nx_we_n;
            SRAM_OE_N <= nx_oe_n;
            SRAM_LB_N <= nx_lb_n;
            SRAM_UB_N <= nx_ub_n;
            dq_oe     <= nx_dq_oe;
            dq_out    <= nx_dq_out;
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // ---------------- Read capture ----------------
    // Beats are collected in rd_buf so o_rdata only changes when the whole
    // word is complete.
    always_comb begin
        int bc;
        bc       = int'(beat);
        rd_merge = rd_buf;
        rd_merge[16*bc +: 16] = SRAM_DQ;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_buf  <= '0;
            o_rdata <= '0;
        end else begin
            if (cap) begin
                rd_buf <= rd_merge;
            end
            if (cap_last) begin
                o_rdata <= rd_merge;
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;

    localparam int AW    = 18;
    localparam int BEATS = 2;
    localparam int WC    = 1;
    localparam int HW    = 16 * BEATS;
    localparam int HAW   = AW - 1;
    localparam int BEW   = 2 * BEATS;
    localparam int LAT_MAX = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            i_req, i_we;
    logic [HAW-1:0]  i_addr;
    logic [HW-1:0]   i_wdata;
    logic [BEW-1:0]  i_be;
    logic            o_ready, o_ack;
    logic [HW-1:0]   o_rdata;
    logic [AW-1:0]   sram_addr;
    wire  [15:0]     sram_dq;
    logic            ce_n, we_n, oe_n, lb_n, ub_n;

    sram_bridge #(.SRAM_AW(AW), .BEATS(BEATS), .WAIT_CYC(WC)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (i_req),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_be      (i_be),
        .o_ready   (o_ready),
        .o_ack     (o_ack),
        .o_rdata   (o_rdata),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (ce_n),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_LB_N (lb_n),
        .SRAM_UB_N (ub_n)
    );

    // ---------------- behavioural SRAM ----------------
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_word(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic void ref_write(input logic [HAW-1:0] addr,
                                      input logic [HW-1:0] wdata,
                                      input logic [BEW-1:0] be);
        for (int b = 0; b < BEATS; b++) begin
            int a;
            logic [15:0] w;
            a = int'(addr) * BEATS + b;
            w = ref_word(a);
            if (be[2*b])   w[7:0]  = wdata[16*b +: 8];
            if (be[2*b+1]) w[15:8] = wdata[16*b+8 +: 8];
            if (be[2*b +: 2] != 2'b00) ref_mem[a] = w;
        end
    endfunction

    function automatic logic [HW-1:0] ref_read(input logic [HAW-1:0] addr);
        logic [HW-1:0] r;
        for (int b = 0; b < BEATS; b++) r[16*b +: 16] = ref_word(int'(addr) * BEATS + b);
        return r;
    endfunction

    function automatic int n_beats(input logic [BEW-1:0] be);
        int n;
        n = 0;
        for (int b = 0; b < BEATS; b++) if (be[2*b +: 2] != 2'b00) n++;
        return n;
    endfunction

    function automatic int ref_lat(input logic we, input logic [BEW-1:0] be);
        return we ? n_beats(be) * (WC + 2) + 1 : BEATS * (WC + 1) + 1;
    endfunction

    // ---------------- scoreboard ----------------
    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [HW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Waits for o_ready, issues one request, scrambles the inputs right after
    // acceptance, and follows the transfer up to o_ack. Returns on the
    // falling edge inside the o_ack cycle.
    task automatic run_txn(input logic we, input logic [HAW-1:0] addr,
                           input logic [HW-1:0] wdata, input logic [BEW-1:0] be,
                           output logic [HW-1:0] rd, output int lat,
                           output int we_c, output int oe_c, output int ub_c,
                           output int wt, output bit to);
        bit seen;
        rd = '0; lat = 0; we_c = 0; oe_c = 0; ub_c = 0; wt = 0; to = 1'b0;
        @(negedge clk);
        while (!o_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        if (!o_ready) begin
            to = 1'b1;
            return;
        end
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_be = be;
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= LAT_MAX && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                i_req   = 1'b0;
                i_we    = 1'($urandom_range(0, 1));
                i_addr  = HAW'($urandom);
                i_wdata = HW'($urandom);
                i_be    = BEW'($urandom);
            end
            if (!we_n) we_c++;
            if (!oe_n) oe_c++;
            if (!we_n && !ub_n) ub_c++;
            if (o_ack) begin
                seen = 1'b1;
                lat  = k;
                rd   = o_rdata;
            end
        end
        if (!seen) to = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic           we;
        logic [HAW-1:0] addr;
        logic [HW-1:0]  wdata;
        logic [BEW-1:0] be;
        logic [HW-1:0]  exp_rd;
        int             exp_lat;
        int             exp_we;
        int             exp_oe;
        int             exp_ub;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [HW-1:0] rd;
        int lat, we_c, oe_c, ub_c, wt, acks;
        bit to;

        vecs[0] = '{1'b1, 17'h100, 32'hBEEF_1234, 4'hF, 32'h0,         7, 4, 0, 4};
        vecs[1] = '{1'b0, 17'h100, 32'h0,         4'hF, 32'hBEEF_1234, 5, 0, 4, 0};
        vecs[2] = '{1'b1, 17'h100, 32'hAA55_0000, 4'h4, 32'h0,         4, 2, 0, 0};
        vecs[3] = '{1'b0, 17'h100, 32'h0,         4'h0, 32'hBE55_1234, 5, 0, 4, 0};
        vecs[4] = '{1'b1, 17'h100, 32'hFFFF_FFFF, 4'h0, 32'h0,         1, 0, 0, 0};
        vecs[5] = '{1'b0, 17'h100, 32'h0,         4'hF, 32'hBE55_1234, 5, 0, 4, 0};
        vecs[6] = '{1'b1, 17'h080, 32'h1357_9BDF, 4'h3, 32'h0,         4, 2, 0, 2};
        vecs[7] = '{1'b0, 17'h080, 32'h0,         4'hF, 32'h0000_9BDF, 5, 0, 4, 0};

        rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst o_ready", 64'(o_ready), 64'd1);
        chk("rst o_ack", 64'(o_ack), 64'd0);
        chk("rst o_rdata", 64'(o_rdata), 64'd0);
        chk("rst sram_addr", 64'(sram_addr), 64'd0);
        chk("rst strobes", 64'({ce_n, we_n, oe_n, lb_n, ub_n}), 64'h1F);
        rst_n = 1'b1;

        // table-driven directed transfers
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else exp_q.push_back(vecs[i].exp_rd);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    rd, lat, we_c, oe_c, ub_c, wt, to);
            chk($sformatf("vec%0d timeout", i), 64'(to), 64'd0);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d we_n low cycles", i), 64'(we_c), 64'(vecs[i].exp_we));
            chk($sformatf("vec%0d oe_n low cycles", i), 64'(oe_c), 64'(vecs[i].exp_oe));
            chk($sformatf("vec%0d ub write cycles", i), 64'(ub_c), 64'(vecs[i].exp_ub));
            if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(exp_q.pop_front()));
        end
        chk("mem 0x200", 64'(sram_mem[18'h200]), 64'h1234);
        chk("mem 0x201", 64'(sram_mem[18'h201]), 64'hBE55);
        chk("mem 0x100", 64'(sram_mem[18'h100]), 64'h9BDF);

        // back-to-back write then read, and no acceptance while o_ack is high
        ref_write(17'h040, 32'hC0DE_F00D, 4'hF);
        run_txn(1'b1, 17'h040, 32'hC0DE_F00D, 4'hF, rd, lat, we_c, oe_c, ub_c, wt, to);
        chk("b2b write timeout", 64'(to), 64'd0);
        run_txn(1'b0, 17'h040, 32'h0, 4'h0, rd, lat, we_c, oe_c, ub_c, wt, to);
        chk("b2b read wait", 64'(wt), 64'd0);
        chk("b2b read latency", 64'(lat), 64'(ref_lat(1'b0, 4'h0)));
        chk("b2b read we_n low", 64'(we_c), 64'd0);
        chk("b2b read rdata", 64'(rd), 64'(ref_read(17'h040)));
        i_req = 1'b1; i_we = 1'b0; i_addr = 17'h040;
        @(negedge clk);
        chk("no accept in done", 64'(o_ready), 64'd1);
        i_req = 1'b0;

        // randomized transfers against the reference model
        for (int n = 0; n < 60; n++) begin
            logic           we;
            logic [HAW-1:0] addr;
            logic [HW-1:0]  wdata;
            logic [BEW-1:0] be;
            we    = 1'($urandom_range(0, 1));
            addr  = HAW'($urandom_range(0, 15));
            wdata = HW'($urandom);
            be    = BEW'($urandom_range(0, 15));
            if (we) ref_write(addr, wdata, be);
            else exp_q.push_back(ref_read(addr));
            run_txn(we, addr, wdata, be, rd, lat, we_c, oe_c, ub_c, wt, to);
            chk($sformatf("rnd%0d timeout", n), 64'(to), 64'd0);
            chk($sformatf("rnd%0d latency", n), 64'(lat), 64'(ref_lat(we, be)));
            chk($sformatf("rnd%0d we_n low cycles", n), 64'(we_c),
                64'(we ? n_beats(be) * (WC + 1) : 0));
            if (!we) chk($sformatf("rnd%0d rdata", n), 64'(rd), 64'(exp_q.pop_front()));
        end

        // reset in the middle of the second read beat
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 17'h100;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) i_req = 1'b0;
        end
        chk("mid-read sram_addr", 64'(sram_addr), 64'h201);
        chk("mid-read oe_n", 64'(oe_n), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort strobes", 64'({ce_n, we_n, oe_n, lb_n, ub_n}), 64'h1F);
        chk("abort o_rdata", 64'(o_rdata), 64'd0);
        chk("abort o_ack", 64'(o_ack), 64'd0);
        chk("abort o_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_ack) acks++;
        end
        chk("abort no ack", 64'(acks), 64'd0);
        exp_q.push_back(ref_read(17'h100));
        run_txn(1'b0, 17'h100, 32'h0, 4'h0, rd, lat, we_c, oe_c, ub_c, wt, to);
        chk("post-reset latency", 64'(lat), 64'd5);
        chk("post-reset rdata", 64'(rd), 64'(exp_q.pop_front()));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
